// File: rtl/mem_ctrl_arb.sv
// Arbitrates instruction fetches and load/stores onto a byte-wide RAM bus.
// Define MEMCTRL_RR_ARB_EN for round-robin arbitration instead of fixed mem priority.
module mem_ctrl_arb #(
    parameter int unsigned RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_needed_in,
    input  logic [31:0]               inst_addr_in,
    output logic [31:0]               inst_data_out,
    output logic                      inst_rdy_out,
    output logic                      inst_busy_out,
    input  logic                      mem_needed_in,
    input  logic                      mem_we_in,
    input  logic [2:0]                mem_len_in,
    input  logic [31:0]               mem_addr_in,
    input  logic [31:0]               mem_wdata_in,
    output logic [31:0]               mem_rdata_out,
    output logic                      mem_rdy_out,
    output logic                      mem_busy_out,
    output logic                      ram_rw_out,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
    output logic [7:0]                ram_dout,
    input  logic [7:0]                ram_din
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic        port_inst_q;
    logic [31:0] inst_data_q;
    logic [31:0] mem_data_q;

    logic        grant_mem, grant_inst;
    logic [2:0]  mem_len;
    logic [1:0]  cap_idx;
    logic [31:0] cur_addr;
    logic        unused_addr;

    always_comb begin
        unique case (mem_len_in)
            3'd1:    mem_len = 3'd1;
            3'd2:    mem_len = 3'd2;
            default: mem_len = 3'd4;
        endcase
    end

`ifdef MEMCTRL_RR_ARB_EN
    logic last_inst_q;

    // On a tie, the port not served most recently wins.
    assign grant_mem  = mem_needed_in && (!inst_needed_in || last_inst_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_inst_q <= 1'b1;
        end else if (state_q == StIdle && (grant_mem || grant_inst)) begin
            last_inst_q <= grant_inst;
        end
    end
`else
    assign grant_mem  = mem_needed_in;
`endif
    assign grant_inst = inst_needed_in && !grant_mem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_mem) begin
                    state_d = mem_we_in ? StWrite : StRead;
                end else if (grant_inst) begin
                    state_d = StRead;
                end
            end
            StRead:  if (cnt_q == len_q) state_d = StDone;
            StWrite: if (cnt_q == len_q - 3'd1) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Byte captured in read cycle k belongs to the address presented in cycle k-1.
    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            port_inst_q <= 1'b0;
            inst_data_q <= '0;
            mem_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_mem || grant_inst) begin
                        port_inst_q <= grant_inst;
                        addr_q      <= grant_mem ? mem_addr_in : inst_addr_in;
                        len_q       <= grant_mem ? mem_len : 3'd4;
                        wdata_q     <= grant_mem ? mem_wdata_in : 32'd0;
                        data_q      <= '0;
                        cnt_q       <= '0;
                    end
                end
                StRead: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        data_q[{cap_idx, 3'b000} +: 8] <= ram_din;
                    end
                end
                StWrite: cnt_q <= cnt_q + 3'd1;
                StDone: begin
                    cnt_q <= '0;
                    if (port_inst_q) begin
                        inst_data_q <= data_q;
                    end else begin
                        mem_data_q <= data_q;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign cur_addr    = addr_q + {29'd0, cnt_q};
    assign unused_addr = ^cur_addr[31:RAM_ADDR_WIDTH];

    // Output logic
    always_comb begin
        inst_busy_out = (state_q != StIdle);
        mem_busy_out  = (state_q != StIdle);
        inst_rdy_out  = (state_q == StDone) && port_inst_q;
        mem_rdy_out   = (state_q == StDone) && !port_inst_q;
        inst_data_out = inst_rdy_out ? data_q : inst_data_q;
        mem_rdata_out = mem_rdy_out ? data_q : mem_data_q;
        ram_rw_out    = 1'b0;
        ram_addr_out  = '0;
        ram_dout      = '0;
        unique case (state_q)
            StRead: begin
                if (cnt_q < len_q) begin
                    ram_addr_out = cur_addr[RAM_ADDR_WIDTH-1:0];
                end
            end
            StWrite: begin
                ram_rw_out   = 1'b1;
                ram_addr_out = cur_addr[RAM_ADDR_WIDTH-1:0];
                ram_dout     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_ctrl_arb.md
Name: mem_ctrl_arb

Overview:
- Responder end of the instruction-fetch request protocol, plus a second requester port for load/store.
- Accepts word fetches from the fetch stage and 1/2/4-byte loads/stores from the MEM stage, arbitrates between them, and serialises each transaction onto the byte-wide RAM bus.
- Returns assembled data with a one-cycle ready pulse and a busy indication that requesters use to hold off.

Parameters:
- RAM_ADDR_WIDTH, 17, number of low address bits driven onto the RAM; upper bits are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- inst_needed_in  in  1  fetch request, held until ready
- inst_addr_in  in  32  fetch byte address
- inst_data_out  out  32  fetched word
- inst_rdy_out  out  1  one-cycle pulse: inst_data_out valid
- inst_busy_out  out  1  controller mid-transaction
- mem_needed_in  in  1  load/store request, held until ready
- mem_we_in  in  1  1 = store, 0 = load
- mem_len_in  in  3  byte count: 1, 2 or 4
- mem_addr_in  in  32  load/store byte address
- mem_wdata_in  in  32  store data; low mem_len_in bytes used
- mem_rdata_out  out  32  load data, zero-extended
- mem_rdy_out  out  1  one-cycle pulse: load/store complete
- mem_busy_out  out  1  controller mid-transaction
- ram_rw_out  out  1  1 = write cycle
- ram_addr_out  out  RAM_ADDR_WIDTH  RAM byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte; reflects the address presented in the previous cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: every output is 0. State is IDLE, byte counter 0, latched address/length/data 0.
- Reset mid-transaction:
  - Aborts the transaction at the next edge.
  - ram_rw_out = 0 from the following cycle.
  - No rdy pulse is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples requests at each edge.
  - Only one request pending: it is accepted.
  - Both pending: mem port wins (fixed priority).
  - On accept, latch port id, address, len (inst = 4) and wdata. Go to READ (inst, or mem load) or WRITE (mem store).
- Busy outputs: inst_busy_out = mem_busy_out = (state != IDLE), registered.
- READ, len L, address A:
  - Cycles c1..cL: drive ram_addr_out = A + k (k = 0..L-1), ram_rw_out = 0.
  - Cycles c2..c(L+1): capture ram_din into byte k-1 of the data register; byte i goes to bits [8i+7:8i] (little-endian).
  - After c(L+1), go to DONE.
- WRITE, len L:
  - Cycles c1..cL: ram_rw_out = 1, ram_addr_out = A + k, ram_dout = wdata byte k.
  - After cL, go to DONE.
- DONE (exactly one cycle):
  - Assert the served port's rdy and drive its data_out. Unread bytes are 0.
  - Requests are ignored in DONE.
  - Next state is IDLE.
- Latency from the accepting edge to the rdy cycle: read L+2 cycles, write L+1 cycles.
- inst_data_out / mem_rdata_out hold their value until that port's next DONE.
- Address arithmetic: 32-bit wrap; ram_addr_out is the low RAM_ADDR_WIDTH bits.
- Outside WRITE, ram_rw_out = 0 and ram_dout = 0.
- mem_len_in values other than 1/2/4: treated as 4.
- Requesters must hold need/addr stable until rdy and drop need in or after the rdy cycle. A request still high in the IDLE cycle after DONE starts a new transaction.

Optional Feature:
- Macro: MEMCTRL_RR_ARB_EN.
- Defined:
  - On simultaneous requests in IDLE, the port not served most recently wins.
  - The last-served flag is set at each accept; rst sets it to "inst served", so mem wins first.
  - A single pending request is accepted regardless of the flag.
- Undefined: fixed priority, mem always wins.

Test Plan:
- Fetch, RAM[0x100..0x103] = 13,05,00,00, inst_needed_in = 1, addr 0x100 -> ram_addr_out 0x100..0x103 in c1..c4; inst_rdy_out = 1 for one cycle at c6; inst_data_out = 0x00000513; busy high c1..c6.
- Store word 0xDEADBEEF to 0x200, len 4 -> ram_rw_out = 1 in c1..c4 with bytes EF, BE, AD, DE at 0x200..0x203; mem_rdy_out at c5.
- Load byte from 0x201 holding 0xBE -> mem_rdata_out = 0x000000BE; mem_rdy_out at c3.
- Fetch and load requested on the same edge -> load served first; fetch accepted in the IDLE cycle after DONE. With MEMCTRL_RR_ARB_EN, a second simultaneous pair serves fetch first.
- rst asserted at c2 of a 4-byte store -> ram_rw_out = 0 from c3; no rdy pulse; all outputs 0; next request behaves normally.
- Fetch at 0xFFFFFFFE with RAM_ADDR_WIDTH = 17 -> ram_addr_out 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
